// File: rtl/mult_pkg.sv
// Shared types and constants for the SIMD multiply-accumulate pipeline.
// Holds the mode encoding, accumulator op codes and the per-beat tag.
package mult_pkg;

   localparam logic MODE_FULL = 1'b0;
   localparam logic MODE_HALF = 1'b1;

   typedef enum logic [1:0] {
      OP_LOAD,
      OP_ADD,
      OP_PASS
   } acc_op_t;

   typedef struct packed {
      logic half;
      logic acc_en;
      logic acc_clr;
   } beat_tag_t;

   function automatic int lw(input int acc_width);
      return acc_width / 2;
   endfunction

endpackage

// File: rtl/multiplier_simd_core.sv
// Valid-tagged product pipeline: full-width or two-lane SIMD product,
// sign-extended and lane-packed to ACC_WIDTH, delayed by PIPE registers.
module multiplier_simd_core
   import mult_pkg::*;
#(
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int PIPE      = 2,
   parameter int ACC_WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   A,
   input  logic [B_WIDTH-1:0]   B,
   input  logic                 A_sign,
   input  logic                 B_sign,
   input  logic                 HALF_0,
   input  logic                 acc_en,
   input  logic                 acc_clr,
   output logic                 prod_valid,
   output logic [ACC_WIDTH-1:0] prod,
   output beat_tag_t            prod_tag
);

   localparam int LW = lw(ACC_WIDTH);
   localparam int HA = A_WIDTH / 2;
   localparam int HB = B_WIDTH / 2;
   localparam int FP = A_WIDTH + B_WIDTH + 2;
   localparam int HP = HA + HB + 2;
   localparam int FW = (FP > ACC_WIDTH) ? FP : ACC_WIDTH;
   localparam int HW = (HP > LW) ? HP : LW;

   logic a_ext;
   logic b_ext;
   logic a_lo_ext;
   logic b_lo_ext;

   assign a_ext    = A_sign & A[A_WIDTH-1];
   assign b_ext    = B_sign & B[B_WIDTH-1];
   assign a_lo_ext = A_sign & A[HA-1];
   assign b_lo_ext = B_sign & B[HB-1];

   // Operands are pre-extended to the product width, so an unsigned
   // multiply yields the exact two's complement product bits.
   logic [FW-1:0] fa;
   logic [FW-1:0] fb;
   logic [FW-1:0] fp;
   logic [HW-1:0] la;
   logic [HW-1:0] lb;
   logic [HW-1:0] lp;
   logic [HW-1:0] ha;
   logic [HW-1:0] hb;
   logic [HW-1:0] hp;

   assign fa = {{(FW-A_WIDTH){a_ext}}, A};
   assign fb = {{(FW-B_WIDTH){b_ext}}, B};
   assign fp = fa * fb;

   assign la = {{(HW-HA){a_lo_ext}}, A[HA-1:0]};
   assign lb = {{(HW-HB){b_lo_ext}}, B[HB-1:0]};
   assign lp = la * lb;

   assign ha = {{(HW-HA){a_ext}}, A[A_WIDTH-1:HA]};
   assign hb = {{(HW-HB){b_ext}}, B[B_WIDTH-1:HB]};
   assign hp = ha * hb;

   logic [ACC_WIDTH-1:0] packed_prod;
   beat_tag_t            tag_in;

   assign packed_prod = (HALF_0 == MODE_HALF)
                      ? {hp[LW-1:0], lp[LW-1:0]}
                      : fp[ACC_WIDTH-1:0];

   assign tag_in.half    = HALF_0;
   assign tag_in.acc_en  = acc_en;
   assign tag_in.acc_clr = acc_clr;

   logic                 v [PIPE];
   logic [ACC_WIDTH-1:0] p [PIPE];
   beat_tag_t            t [PIPE];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PIPE; i++) begin
            v[i] <= 1'b0;
         end
      end else begin
         v[0] <= in_valid;
         for (int i = 1; i < PIPE; i++) begin
            v[i] <= v[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         p[0] <= packed_prod;
         t[0] <= tag_in;
      end
      for (int i = 1; i < PIPE; i++) begin
         p[i] <= p[i-1];
         t[i] <= t[i-1];
      end
   end

   assign prod_valid = v[PIPE-1];
   assign prod       = p[PIPE-1];
   assign prod_tag   = t[PIPE-1];

endmodule

// File: rtl/multiplier_simd_mac_pipe.sv
// Pipelined signed/unsigned multiplier with a lane-splittable accumulator.
// HALF_0 selects two independent half-width lanes with no carry between.
module multiplier_simd_mac_pipe
   import mult_pkg::*;
#(
   parameter int A_WIDTH = 8,
   parameter int B_WIDTH = 8,
   parameter int PIPE    = 2,
   parameter int GUARD   = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   input  logic [A_WIDTH-1:0]                   A,
   input  logic [B_WIDTH-1:0]                   B,
   input  logic                                 A_sign,
   input  logic                                 B_sign,
   input  logic                                 HALF_0,
   input  logic                                 acc_en,
   input  logic                                 acc_clr,
   output logic                                 out_valid,
   output logic [A_WIDTH+B_WIDTH+GUARD-1:0]     C
);

   localparam int ACC_WIDTH = A_WIDTH + B_WIDTH + GUARD;
   localparam int LW        = lw(ACC_WIDTH);

   if ((A_WIDTH % 2 != 0) || (A_WIDTH < 4) ||
       (B_WIDTH % 2 != 0) || (B_WIDTH < 4) ||
       (GUARD % 2 != 0) || (GUARD < 0) || (PIPE < 1)) begin : g_bad_param
      $error("multiplier_simd_mac_pipe: illegal parameter set");
   end

   logic                 prod_valid;
   logic [ACC_WIDTH-1:0] prod;
   beat_tag_t            tag;

   multiplier_simd_core #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .PIPE      (PIPE),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .A          (A),
      .B          (B),
      .A_sign     (A_sign),
      .B_sign     (B_sign),
      .HALF_0     (HALF_0),
      .acc_en     (acc_en),
      .acc_clr    (acc_clr),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_tag   (tag)
   );

   logic                 last_mode;
   logic [ACC_WIDTH-1:0] acc;
   acc_op_t              op;

   // Priority matters here: clear beats add, and a mode change restarts.
   always_comb begin
      op = OP_PASS;
      if (tag.acc_clr) begin
         op = OP_LOAD;
      end else if (tag.acc_en && (tag.half != last_mode)) begin
         op = OP_LOAD;
      end else if (tag.acc_en) begin
         op = OP_ADD;
      end
   end

   logic [ACC_WIDTH-1:0] sum_full;
   logic [ACC_WIDTH-1:0] sum_half;
   logic [ACC_WIDTH-1:0] acc_next;

   assign sum_full = acc + prod;
   assign sum_half = {acc[ACC_WIDTH-1:LW] + prod[ACC_WIDTH-1:LW],
                      acc[LW-1:0] + prod[LW-1:0]};

   always_comb begin
      acc_next = prod;
      if (op == OP_ADD) begin
         acc_next = (tag.half == MODE_HALF) ? sum_half : sum_full;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         out_valid <= 1'b0;
         last_mode <= MODE_FULL;
      end else begin
         out_valid <= prod_valid;
         if (prod_valid) begin
            acc       <= acc_next;
            last_mode <= tag.half;
         end
      end
   end

   assign C = acc;

endmodule

// File: tb/tb_multiplier_simd_mac_pipe.sv
// Directed bench for multiplier_simd_mac_pipe at default parameters.
// Checks latency, accumulate, SIMD lanes, wrap, mode switch and reset.
module tb_multiplier_simd_mac_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        A_sign;
   logic        B_sign;
   logic        HALF_0;
   logic        acc_en;
   logic        acc_clr;
   logic        out_valid;
   logic [19:0] C;

   int n_chk;
   int n_pass;
   int n_fail;

   multiplier_simd_mac_pipe #(
      .A_WIDTH (8),
      .B_WIDTH (8),
      .PIPE    (2),
      .GUARD   (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .A_sign    (A_sign),
      .B_sign    (B_sign),
      .HALF_0    (HALF_0),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .C         (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] obs,
                      input logic [19:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] b,
                       input logic as, input logic bs, input logic hf,
                       input logic en, input logic clr);
      A        = a;
      B        = b;
      A_sign   = as;
      B_sign   = bs;
      HALF_0   = hf;
      acc_en   = en;
      acc_clr  = clr;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Idle cycles drive junk on every sampled input to prove it is ignored.
   task automatic idle();
      in_valid = 1'b0;
      A        = 8'($urandom);
      B        = 8'($urandom);
      A_sign   = 1'($urandom);
      B_sign   = 1'($urandom);
      HALF_0   = 1'($urandom);
      acc_en   = 1'b1;
      acc_clr  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      n_fail   = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      A_sign   = 1'b0;
      B_sign   = 1'b0;
      HALF_0   = 1'b0;
      acc_en   = 1'b0;
      acc_clr  = 1'b0;

      idle();
      idle();
      chk("rst_ov", 20'(out_valid), 20'd0);
      chk("rst_c", C, 20'h00000);
      reset = 1'b0;
      idle();
      chk("post_rst_ov", 20'(out_valid), 20'd0);

      // signed -128 * 127, latency PIPE+1
      beat(8'h80, 8'h7F, 1, 1, 0, 0, 1);
      idle();
      chk("lat_early_ov", 20'(out_valid), 20'd0);
      idle();
      chk("lat_ov", 20'(out_valid), 20'd1);
      chk("signed_c", C, 20'hFC080);
      idle();
      chk("bubble_ov", 20'(out_valid), 20'd0);
      chk("bubble_hold", C, 20'hFC080);

      // unsigned back-to-back accumulate
      beat(8'hFF, 8'hFF, 0, 0, 0, 0, 1);
      beat(8'hFF, 8'hFF, 0, 0, 0, 1, 0);
      beat(8'hFF, 8'hFF, 0, 0, 0, 1, 0);
      chk("acc1_ov", 20'(out_valid), 20'd1);
      chk("acc1_c", C, 20'h0FE01);
      beat(8'hFF, 8'hFF, 0, 0, 0, 1, 0);
      chk("acc2_ov", 20'(out_valid), 20'd1);
      chk("acc2_c", C, 20'h1FC02);
      idle();
      chk("acc3_ov", 20'(out_valid), 20'd1);
      chk("acc3_c", C, 20'h2FA03);
      idle();
      chk("acc4_ov", 20'(out_valid), 20'd1);
      chk("acc4_c", C, 20'h3F804);
      idle();
      chk("acc_end_ov", 20'(out_valid), 20'd0);

      // half mode signed: hi=-1*2, lo=3*5
      beat(8'hF3, 8'h25, 1, 1, 1, 0, 1);
      beat(8'hF3, 8'h25, 1, 1, 1, 1, 0);
      idle();
      chk("half_c", C, 20'hFF80F);
      idle();
      chk("half_acc_c", C, 20'hFF01E);

      // 17 unsigned 0xFF*0xFF products wrap modulo 2^20
      beat(8'hFF, 8'hFF, 0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         beat(8'hFF, 8'hFF, 0, 0, 0, 1, 0);
      end
      idle();
      idle();
      chk("wrap_ov", 20'(out_valid), 20'd1);
      chk("wrap_c", C, 20'h0DE11);
      idle();
      chk("wrap_end_ov", 20'(out_valid), 20'd0);

      // two full beats then a half beat with acc_en: implicit clear
      beat(8'h03, 8'h05, 0, 0, 0, 0, 1);
      beat(8'h02, 8'h07, 0, 0, 0, 1, 0);
      beat(8'h12, 8'h34, 0, 0, 1, 1, 0);
      chk("mode_a_c", C, 20'h0000F);
      idle();
      chk("mode_b_c", C, 20'h0001D);
      idle();
      chk("mode_sw_c", C, 20'h00C08);

      // clr and en both high: clr loads; then pass-through beat
      beat(8'h0A, 8'h0A, 0, 0, 0, 1, 1);
      beat(8'h10, 8'h10, 0, 0, 0, 0, 0);
      idle();
      chk("clr_en_c", C, 20'h00064);
      idle();
      chk("pass_c", C, 20'h00100);

      // mixed signs: A signed -1, B unsigned 255
      beat(8'hFF, 8'hFF, 1, 0, 0, 0, 1);
      idle();
      idle();
      chk("mixed_c", C, 20'hFFF01);

      // reset mid-stream discards in-flight beats
      beat(8'h01, 8'h01, 0, 0, 0, 0, 1);
      beat(8'h01, 8'h01, 0, 0, 0, 1, 0);
      beat(8'h01, 8'h01, 0, 0, 0, 1, 0);
      reset = 1'b1;
      idle();
      chk("mid_rst_ov", 20'(out_valid), 20'd0);
      chk("mid_rst_c", C, 20'h00000);
      reset = 1'b0;
      idle();
      chk("rel_ov", 20'(out_valid), 20'd0);
      chk("rel_c", C, 20'h00000);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("drain_ov", 20'(out_valid), 20'd0);
      end
      beat(8'h02, 8'h03, 0, 0, 0, 1, 0);
      idle();
      idle();
      chk("after_rst_ov", 20'(out_valid), 20'd1);
      chk("after_rst_c", C, 20'h00006);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multiplier_simd_mac_pipe.md
Name: multiplier_simd_mac_pipe

Overview:
- Parametrised, pipelined signed/unsigned multiplier with multiply-accumulate.
- Runtime HALF_0 mode splits the datapath into two independent half-width SIMD lanes.
- Valid-tagged pipeline feeds a lane-splittable accumulator.
- Used as the next-generation PE multiplier in the DSP tile; supersedes the fixed 8x8 single-register multiplier.

Parameters:
- A_WIDTH, 8, A operand width; must be even and >= 4.
- B_WIDTH, 8, B operand width; must be even and >= 4.
- PIPE, 2, number of product register stages (>= 1) before the accumulator stage.
- GUARD, 4, accumulator guard bits; must be even.
- ACC_WIDTH, A_WIDTH+B_WIDTH+GUARD, derived; not overridable. Half-mode lane width is LW = ACC_WIDTH/2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- A  in  A_WIDTH  multiplicand.
- B  in  B_WIDTH  multiplier.
- A_sign  in  1  1 = A signed (two's complement).
- B_sign  in  1  1 = B signed.
- HALF_0  in  1  1 = two-lane SIMD mode; 0 = full-width mode.
- acc_en  in  1  accumulate this beat into the running sum.
- acc_clr  in  1  start a new sum with this beat.
- out_valid  out  1  C holds a new result.
- C  out  ACC_WIDTH  result or running sum.

Behaviour:
- Reset: out_valid=0, C=0, accumulator=0, all pipeline valid bits=0. Reset mid-operation discards every in-flight beat; no out_valid may be asserted in the cycle after reset deasserts.
- Sampling: A, B, sign bits, HALF_0, acc_en and acc_clr are sampled only when in_valid=1. All of them travel with the beat through the pipeline.
- Latency: out_valid rises exactly PIPE+1 cycles after in_valid. Throughput is one beat per cycle. There is no backpressure.
- Bubbles (in_valid=0) propagate as invalid. While no valid beat reaches the accumulator stage, C and the accumulator hold and out_valid=0.
- Full mode:
  - Operand extension bit = MSB & sign flag for each operand.
  - Product is computed at (A_WIDTH+1)x(B_WIDTH+1) signed, then sign-extended to ACC_WIDTH.
- Half mode:
  - Lo lane uses A[A_WIDTH/2-1:0] x B[B_WIDTH/2-1:0]; hi lane uses the upper halves.
  - Each lane's extension bit = lane MSB & sign flag. A_sign and B_sign apply to both lanes.
  - Each product is sign-extended to LW.
  - C = {hi_lane, lo_lane}. There is no carry between lanes, ever.
- Accumulator stage, for each valid beat, in priority order:
  1. acc_clr=1: acc <= product.
  2. acc_en=1 and the beat's HALF_0 differs from the mode of the previous accumulated beat: acc <= product (implicit clear).
  3. acc_en=1: acc <= acc + product.
  4. Otherwise: acc <= product (pass-through, single-product result).
- In every case C <= new acc value and out_valid=1.
- Overflow wraps modulo 2^ACC_WIDTH in full mode and modulo 2^LW per lane in half mode. There is no saturation and no flag.
- acc_clr and acc_en both high: acc_clr wins. The beat's product is loaded, not lost.
- Operand flags may change every beat. Mixed signed/unsigned operand pairs are legal.

Decomposition:
- Shared package mult_pkg:
  - lane-width function lw(acc_width);
  - HALF_0 encoding constants MODE_FULL=0, MODE_HALF=1;
  - accumulator-op encoding (LOAD, ADD, PASS) for the op decode.
- One sub-module, multiplier_simd_core:
  - the PIPE-stage, valid-tagged product pipeline emitting the sign-extended, lane-packed ACC_WIDTH product plus the tag bits;
  - the top level adds op decode, mode tracking and the accumulator.

Test Plan:
- Defaults; full mode; A=0x80, B=0x7F, A_sign=B_sign=1, acc_clr=1 -> after 3 cycles out_valid=1, C=0xFC080 (-16256).
- Full mode unsigned; A=B=0xFF; beat 1 acc_clr=1, beats 2-4 acc_en=1, back-to-back -> C sequence 0x0FE01, 0x1FC02, 0x2FA03, 0x3F804; out_valid high for 4 consecutive cycles.
- Half mode signed; A=0xF3, B=0x25 -> hi=-2, lo=15, C=0xFF80F. Repeat with acc_en=1 -> C=0xFF01E, with no hi/lo carry.
- Wrap: full unsigned 0xFF x 0xFF, acc_clr then 16 acc_en beats -> final C=0x0DE11 (1105425 mod 2^20).
- Mode switch: accumulate 2 full beats, then a HALF_0=1 beat with acc_en=1 -> C equals that beat's half product alone (implicit clear).
- Reset mid-stream:
  - Stimulus: feed 3 valid beats, assert reset one cycle after the third, then release.
  - Required: out_valid=0 and C=0 from the cycle after reset; none of the 3 beats is ever output.
  - Then one beat A=2, B=3 with acc_en=1 -> C=6.
